uart_frame_tx: RTL and testbench
================================

UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
- REQ-001: Parameter CLK_FREQUENCE, default 50_000_000, SHALL be the system clock frequency in Hz.
- REQ-002: Parameter BAUD_RATE, default 9600, SHALL be the line bit rate in baud.
- REQ-003: Parameter PARITY, default "NONE", SHALL select parity: "NONE", "EVEN" or "ODD"; any other value SHALL behave as "NONE".
- REQ-004: Parameter FRAME_WD, default 8, SHALL be the data bits per frame: 5..9 with "NONE", 5..8 otherwise.
- REQ-005: clk  input  1  SHALL be the system clock; all logic is on its rising edge, and the block has one clock only.
- REQ-006: rst  input  1  SHALL be the synchronous, active-high reset.
- REQ-007: frame_en  input  1  SHALL be a one-cycle request to send data_frame.
- REQ-008: data_frame  input  FRAME_WD  SHALL be the payload, sampled only in the cycle a request is accepted.
- REQ-009: uart_tx  output  1  SHALL be the serial line, idle high.
- REQ-010: busy  output  1  SHALL be high while a frame is in progress.
- REQ-011: tx_done  output  1  SHALL be a one-cycle pulse marking frame completion.

Function
- REQ-012: BIT_CYC SHALL equal CLK_FREQUENCE/BAUD_RATE, using truncating integer division, and each line bit SHALL last exactly BIT_CYC clk cycles.
- REQ-013: States SHALL be IDLE, START_BIT, DATA_FRAME, PARITY_BIT, STOP_BIT and DONE.
- REQ-014: A request SHALL be accepted only when the state is IDLE and frame_en=1; in that cycle data_frame SHALL be latched into an internal shift register.
- REQ-015: On the cycle after acceptance, the state SHALL be START_BIT, with uart_tx=0 and busy=1.
- REQ-016: DATA_FRAME SHALL send FRAME_WD bits, LSB first, each for BIT_CYC cycles.
- REQ-017: PARITY_BIT SHALL be entered only if PARITY is "EVEN" or "ODD"; otherwise DATA_FRAME SHALL go directly to STOP_BIT.
- REQ-018: The parity bit SHALL be ^latched_data for "EVEN" and ~^latched_data for "ODD", computed from the latched value, not the live input.
- REQ-019: STOP_BIT SHALL drive uart_tx=1 for BIT_CYC cycles, then move to DONE.
- REQ-020: DONE SHALL last exactly one cycle, with tx_done=1, uart_tx=1 and busy=1, and SHALL then return to IDLE.
- REQ-021: busy SHALL be 0 in IDLE and 1 in every other state.
- REQ-022: Frame latency, from the accept edge to the DONE cycle, SHALL be (2+FRAME_WD+P)*BIT_CYC cycles, where P=1 with parity and P=0 without.
- REQ-023: frame_en SHALL be ignored in every state other than IDLE, including DONE, with no queuing and no effect on the frame in flight.
- REQ-024: A frame_en in the cycle after DONE (state IDLE) SHALL be accepted, so back-to-back frames are separated by exactly one DONE cycle plus the IDLE accept cycle, with uart_tx=1 in both cycles.
- REQ-025: Changes on data_frame after acceptance SHALL NOT alter the frame in flight.
- REQ-026: The baud counter SHALL be cleared on acceptance and at every bit boundary, so no bit is shortened or stretched.
- REQ-027: uart_tx SHALL be driven from a register, with no combinational path from frame_en or data_frame to uart_tx.

Reset
- REQ-028: When rst=1 at a clk edge, the block SHALL enter IDLE with uart_tx=1, busy=0, tx_done=0, and the baud counter, bit counter and shift register at 0.
- REQ-029: A reset asserted mid-frame SHALL abort the frame immediately; uart_tx SHALL be 1 from the next edge, and no tx_done SHALL be produced.
- REQ-030: frame_en asserted in the same cycle as rst=1 SHALL be ignored.

Verification (CLK_FREQUENCE=1_000_000, BAUD_RATE=100_000, so BIT_CYC=10, unless stated)
- REQ-031: PARITY="NONE", FRAME_WD=8, data 0xA5 -> uart_tx carries 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; tx_done pulses exactly 100 cycles after the accept edge; busy is high for 101 cycles.
- REQ-032: PARITY="EVEN", data 0x07 -> parity bit=1 and tx_done at 110 cycles; PARITY="ODD", data 0x07 -> parity bit=0.
- REQ-033: frame_en pulses at cycles 5, 50 and during DONE of a 0x3C frame -> only one frame is sent, with no glitch on uart_tx; data_frame is toggled after acceptance and the transmitted bits still equal 0x3C.
- REQ-034: Back-to-back requests: frame_en is asserted on the first IDLE cycle after tx_done -> the second start bit begins 2 cycles after the tx_done cycle, and the line stays high between the frames.
- REQ-035: rst=1 pulsed at cycle 35 of a 0xFF frame -> uart_tx=1 and busy=0 from the next edge, no tx_done; a new 0x55 request afterwards is sent correctly.
- REQ-036: FRAME_WD=5 with PARITY="NONE", and FRAME_WD=9 with PARITY="NONE", data all ones -> frame lengths of 70 and 110 cycles respectively, with tx_done timing to match.

Source files
------------

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start bit, FRAME_WD data bits LSB first, optional
// even/odd parity bit, one stop bit, then a one-cycle DONE with tx_done.
module uart_frame_tx #(
    parameter int    CLK_FREQUENCE = 50_000_000,
    parameter int    BAUD_RATE     = 9600,
    parameter string PARITY        = "NONE",
    parameter int    FRAME_WD      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_en,
    input  logic [FRAME_WD-1:0] data_frame,
    output logic                uart_tx,
    output logic                busy,
    output logic                tx_done,
    output logic [2:0]          state_dbg
);

    localparam int BIT_CYC = CLK_FREQUENCE / BAUD_RATE;
    localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int BW      = (FRAME_WD > 1) ? $clog2(FRAME_WD) : 1;

    localparam bit PAR_EVEN = (PARITY == "EVEN");
    localparam bit PAR_ODD  = (PARITY == "ODD");
    localparam bit PAR_EN   = PAR_EVEN || PAR_ODD;

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_WD - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_FRAME = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [FRAME_WD-1:0] data_q, data_d;
    logic                tx_q, tx_d;
    logic                bit_end;

    // Handshake: frame_en is a one-cycle valid strobe and !busy is ready; a
    // request transfers only in a cycle where both hold, otherwise it is
    // dropped (never queued).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CNT_ONE;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (frame_en) begin
                    state_d = START_BIT;
                    data_d  = data_frame;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    state_d = DATA_FRAME;
                    tx_d    = data_q[0];
                end
            end
            DATA_FRAME: begin
                if (bit_end) begin
                    // Rotate rather than shift: after FRAME_WD bits the
                    // register holds the latched word again.
                    data_d = {data_q[0], data_q[FRAME_WD-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (PAR_EN) begin
                            state_d = PARITY_BIT;
                            tx_d    = PAR_ODD ? ~^data_q : ^data_q;
                        end else begin
                            state_d = STOP_BIT;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                        tx_d  = data_q[1];
                    end
                end
            end
            PARITY_BIT: begin
                if (bit_end) begin
                    state_d = STOP_BIT;
                    tx_d    = 1'b1;
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    state_d = DONE;
                    tx_d    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign uart_tx   = tx_q;
    assign busy      = (state_q != IDLE);
    assign tx_done   = (state_q == DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: five instances cover no/even/odd
// parity and 5/8/9-bit frames; a scoreboard holds the expected line bits.
module tb_uart_frame_tx;

  localparam int NI = 5;

  logic       clk;
  logic       rst;
  logic [4:0] fen;
  logic [8:0] data_bus;
  logic [4:0] tx_v;
  logic [4:0] busy_v;
  logic [4:0] done_v;
  logic [2:0] st_v [NI];

  int wd_t  [NI] = '{8, 8, 8, 5, 9};
  int par_t [NI] = '{0, 1, 2, 0, 0};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int last_done_cyc = 0;

  logic [11:0] exp_q[$];

  uart_frame_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("NONE"), .FRAME_WD(8)) dut_none8 (
    .clk(clk), .rst(rst), .frame_en(fen[0]), .data_frame(data_bus[7:0]),
    .uart_tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]), .state_dbg(st_v[0]));
  uart_frame_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("EVEN"), .FRAME_WD(8)) dut_even8 (
    .clk(clk), .rst(rst), .frame_en(fen[1]), .data_frame(data_bus[7:0]),
    .uart_tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]), .state_dbg(st_v[1]));
  uart_frame_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("ODD"), .FRAME_WD(8)) dut_odd8 (
    .clk(clk), .rst(rst), .frame_en(fen[2]), .data_frame(data_bus[7:0]),
    .uart_tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]), .state_dbg(st_v[2]));
  uart_frame_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("NONE"), .FRAME_WD(5)) dut_none5 (
    .clk(clk), .rst(rst), .frame_en(fen[3]), .data_frame(data_bus[4:0]),
    .uart_tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]), .state_dbg(st_v[3]));
  uart_frame_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("NONE"), .FRAME_WD(9)) dut_none9 (
    .clk(clk), .rst(rst), .frame_en(fen[4]), .data_frame(data_bus),
    .uart_tx(tx_v[4]), .busy(busy_v[4]), .tx_done(done_v[4]), .state_dbg(st_v[4]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Line image of a frame, bit 0 first on the wire: start, data LSB first,
  // optional parity (1 = even, 2 = odd), stop.
  function automatic logic [11:0] make_frame(input logic [8:0] d, input int w, input int p);
    logic [11:0] f;
    logic x;
    int idx;
    f = '0;
    x = 1'b0;
    for (int i = 0; i < w; i++) begin
      f[1+i] = d[i];
      x = x ^ d[i];
    end
    idx = 1 + w;
    if (p != 0) begin
      f[idx] = (p == 1) ? x : ~x;
      idx++;
    end
    f[idx] = 1'b1;
    return f;
  endfunction

  // driver: call at a negedge; returns #1 after the accept edge
  task automatic send(input int k, input logic [8:0] d, input bit track);
    data_bus = d;
    fen[k] = 1'b1;
    @(posedge clk);
    #1;
    fen[k] = 1'b0;
    accept_cyc = cyc;
    if (track) exp_q.push_back(make_frame(d, wd_t[k], par_t[k]));
  endtask

  // monitor: samples every cycle from the first cycle after accept through
  // the IDLE cycle after DONE; returns on that negedge
  task automatic rx_frame(input int k);
    logic [11:0] exp_f;
    logic [11:0] obs_f;
    logic exp_bit;
    int nb, glitch, done_at, done_n, busy_n;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    exp_f = exp_q.pop_front();
    nb = 2 + wd_t[k] + ((par_t[k] != 0) ? 1 : 0);
    obs_f = '0;
    glitch = 0;
    done_at = -1;
    done_n = 0;
    busy_n = 0;
    for (int i = 0; i <= nb * 10 + 1; i++) begin
      @(negedge clk);
      if (i == 0) check("start_state", int'(st_v[k]), 1);
      exp_bit = (i < nb * 10) ? exp_f[i / 10] : 1'b1;
      if (tx_v[k] !== exp_bit) glitch++;
      if ((i < nb * 10) && (i % 10 == 5)) obs_f[i / 10] = tx_v[k];
      if (done_v[k]) begin
        done_n++;
        if (done_at < 0) begin
          done_at = i;
          last_done_cyc = cyc;
        end
      end
      if (busy_v[k]) busy_n++;
    end
    check("line_bits", int'(obs_f), int'(exp_f));
    check("line_cycles_off", glitch, 0);
    check("done_latency", done_at, nb * 10);
    check("done_pulses", done_n, 1);
    check("busy_cycles", busy_n, nb * 10 + 1);
  endtask

  task automatic idle_watch(input int k, input int n, output int nbusy, output int ndone);
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy_v[k]) nbusy++;
      if (done_v[k]) ndone++;
    end
  endtask

  // extra requests and data churn while a frame is in flight
  task automatic disturb(input int k);
    repeat (5) @(negedge clk);
    fen[k] = 1'b1;
    data_bus = 9'($urandom_range(0, 511));
    @(negedge clk);
    fen[k] = 1'b0;
    data_bus = 9'($urandom_range(0, 511));
    repeat (44) @(negedge clk);
    fen[k] = 1'b1;
    data_bus = 9'($urandom_range(0, 511));
    @(negedge clk);
    fen[k] = 1'b0;
    repeat (50) @(negedge clk);
    fen[k] = 1'b1;
    data_bus = 9'($urandom_range(0, 511));
    @(negedge clk);
    fen[k] = 1'b0;
  endtask

  initial begin
    int nbusy, ndone, first_done;
    rst = 1'b1;
    fen = '0;
    data_bus = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_tx", int'(tx_v[k]), 1);
      check("rst_busy", int'(busy_v[k]), 0);
      check("rst_done", int'(done_v[k]), 0);
      check("rst_state", int'(st_v[k]), 0);
    end

    send(0, 9'h0A5, 1'b1);
    rx_frame(0);
    @(negedge clk);
    send(1, 9'h007, 1'b1);
    rx_frame(1);
    @(negedge clk);
    send(2, 9'h007, 1'b1);
    rx_frame(2);

    @(negedge clk);
    send(0, 9'h03C, 1'b1);
    fork
      rx_frame(0);
      disturb(0);
    join
    idle_watch(0, 30, nbusy, ndone);
    check("ignored_req_busy", nbusy, 0);
    check("ignored_req_done", ndone, 0);

    @(negedge clk);
    send(0, 9'($urandom_range(0, 255)), 1'b1);
    rx_frame(0);
    first_done = last_done_cyc;
    send(0, 9'($urandom_range(0, 255)), 1'b1);
    check("b2b_gap", accept_cyc - first_done, 2);
    rx_frame(0);

    @(negedge clk);
    send(0, 9'h0FF, 1'b0);
    repeat (35) @(negedge clk);
    rst = 1'b1;
    fen[0] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fen[0] = 1'b0;
    @(negedge clk);
    check("abort_tx", int'(tx_v[0]), 1);
    check("abort_busy", int'(busy_v[0]), 0);
    check("abort_state", int'(st_v[0]), 0);
    idle_watch(0, 120, nbusy, ndone);
    check("abort_no_done", ndone, 0);
    check("abort_no_start", nbusy, 0);
    send(0, 9'h055, 1'b1);
    rx_frame(0);

    @(negedge clk);
    send(3, 9'h01F, 1'b1);
    rx_frame(3);
    @(negedge clk);
    send(4, 9'h1FF, 1'b1);
    rx_frame(4);
    @(negedge clk);
    send(4, 9'($urandom_range(0, 511)), 1'b1);
    rx_frame(4);

    check("sb_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
